// File: rtl/vga_scanout.sv
// VGA scan-out for a 256x240 frame buffer, pixel-doubled into a 512x480 window
// on a 640x480@60 raster.
//
// Ports:
//   pix_clk            pixel clock, the only clock
//   reset              synchronous, active-high
//   pix_ptr_x/_y       frame-buffer read address (combinational from counters)
//   rgb                frame-buffer pixel RRRGGGBBB, valid one cycle after the pointers
//   vga_r/g/b          registered colour, 0 during blanking
//   vga_hs/vs          registered syncs, active-low
//   video_on           registered, high while vga_r/g/b carry active-area pixels
//   vblank             registered, high while vcount >= V_ACTIVE
//   frame_start        registered one-cycle pulse after the counters sit at (0,0)
module vga_scanout #(
  parameter int unsigned H_ACTIVE   = 640,
  parameter int unsigned H_FP       = 16,
  parameter int unsigned H_SYNC     = 96,
  parameter int unsigned H_BP       = 48,
  parameter int unsigned V_ACTIVE   = 480,
  parameter int unsigned V_FP       = 10,
  parameter int unsigned V_SYNC     = 2,
  parameter int unsigned V_BP       = 33,
  parameter int unsigned X_OFFSET   = 64,
  parameter logic [8:0]  BORDER_RGB = 9'h000
) (
  input  logic       pix_clk,
  input  logic       reset,
  output logic [7:0] pix_ptr_x,
  output logic [7:0] pix_ptr_y,
  input  logic [8:0] rgb,
  output logic [2:0] vga_r,
  output logic [2:0] vga_g,
  output logic [2:0] vga_b,
  output logic       vga_hs,
  output logic       vga_vs,
  output logic       video_on,
  output logic       vblank,
  output logic       frame_start
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HW      = $clog2(H_TOTAL);
  localparam int unsigned VW      = $clog2(V_TOTAL);

  localparam logic [HW-1:0] HLast = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] HAct  = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HsLo  = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HsHi  = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [HW-1:0] XLo   = HW'(X_OFFSET);
  localparam logic [HW-1:0] XHi   = HW'(X_OFFSET + 512);
  localparam logic [VW-1:0] VLast = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] VAct  = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VsLo  = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VsHi  = VW'(V_ACTIVE + V_FP + V_SYNC);

  logic [HW-1:0] hcount_q, hcount_d;
  logic [VW-1:0] vcount_q, vcount_d;

  // Stage 1: position-derived flags, aligned with the frame-buffer read latency
  logic s1_win_q, s1_act_q, s1_hs_n_q, s1_vs_n_q;
  // Stage 2: output registers
  logic [8:0] rgb_q, rgb_d;
  logic       hs_q, vs_q, video_on_q, vblank_q, frame_start_q;

  logic v_act, in_window, active, hs_n, vs_n;

  always_comb begin
    hcount_d = hcount_q + 1'b1;
    vcount_d = vcount_q;
    if (hcount_q == HLast) begin
      hcount_d = '0;
      vcount_d = (vcount_q == VLast) ? '0 : vcount_q + 1'b1;
    end
  end

  always_comb begin
    v_act     = vcount_q < VAct;
    in_window = (hcount_q >= XLo) && (hcount_q < XHi) && v_act;
    active    = (hcount_q < HAct) && v_act;
    hs_n      = !((hcount_q >= HsLo) && (hcount_q < HsHi));
    vs_n      = !((vcount_q >= VsLo) && (vcount_q < VsHi));
    // Dropping bit 0 of the window-relative column doubles each NES pixel
    pix_ptr_x = in_window ? 8'((hcount_q - XLo) >> 1) : 8'd0;
    pix_ptr_y = v_act ? 8'(vcount_q >> 1) : 8'd0;
  end

  always_comb begin
    rgb_d = 9'd0;
    if (s1_win_q) begin
      rgb_d = rgb;
    end else if (s1_act_q) begin
      rgb_d = BORDER_RGB;
    end
  end

  always_ff @(posedge pix_clk) begin
    if (reset) begin
      hcount_q      <= '0;
      vcount_q      <= '0;
      s1_win_q      <= 1'b0;
      s1_act_q      <= 1'b0;
      s1_hs_n_q     <= 1'b1;
      s1_vs_n_q     <= 1'b1;
      rgb_q         <= '0;
      hs_q          <= 1'b1;
      vs_q          <= 1'b1;
      video_on_q    <= 1'b0;
      vblank_q      <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      hcount_q      <= hcount_d;
      vcount_q      <= vcount_d;
      s1_win_q      <= in_window;
      s1_act_q      <= active;
      s1_hs_n_q     <= hs_n;
      s1_vs_n_q     <= vs_n;
      rgb_q         <= rgb_d;
      hs_q          <= s1_hs_n_q;
      vs_q          <= s1_vs_n_q;
      video_on_q    <= s1_act_q;
      vblank_q      <= !v_act;
      frame_start_q <= (hcount_q == '0) && (vcount_q == '0);
    end
  end

  assign vga_r       = rgb_q[8:6];
  assign vga_g       = rgb_q[5:3];
  assign vga_b       = rgb_q[2:0];
  assign vga_hs      = hs_q;
  assign vga_vs      = vs_q;
  assign video_on    = video_on_q;
  assign vblank      = vblank_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_scanout.sv
module tb_vga_scanout;

  logic       pix_clk = 1'b0;
  logic       reset   = 1'b1;
  logic [7:0] pix_ptr_x, pix_ptr_y;
  logic [8:0] rgb;
  logic [2:0] vga_r, vga_g, vga_b;
  logic       vga_hs, vga_vs, video_on, vblank, frame_start;

  vga_scanout dut (
    .pix_clk     (pix_clk),
    .reset       (reset),
    .pix_ptr_x   (pix_ptr_x),
    .pix_ptr_y   (pix_ptr_y),
    .rgb         (rgb),
    .vga_r       (vga_r),
    .vga_g       (vga_g),
    .vga_b       (vga_b),
    .vga_hs      (vga_hs),
    .vga_vs      (vga_vs),
    .video_on    (video_on),
    .vblank      (vblank),
    .frame_start (frame_start)
  );

  always #20 pix_clk = ~pix_clk;

  // Frame buffer: either the fixed pattern or a random image, 1-cycle read latency
  bit         fb_rand = 1'b0;
  logic [8:0] fb_mem [0:256*240-1];

  function automatic logic [8:0] fb_val(input int x, input int y, input bit rnd);
    if (y >= 240) return 9'd0;
    if (rnd) return fb_mem[y*256 + x];
    return {3'(x), 3'(y), 3'b101};
  endfunction

  always @(posedge pix_clk) rgb <= fb_val(int'(pix_ptr_x), int'(pix_ptr_y), fb_rand);

  // Reference: what a 640x480 raster position should look like on the wire
  function automatic void pixel(input int h, input int v, input bit rnd,
                                output logic [8:0] col, output bit hs, output bit vs,
                                output bit von);
    bit act, win;
    act = (h < 640) && (v < 480);
    win = (h >= 64) && (h < 576) && (v < 480);
    hs  = !((h >= 656) && (h < 752));
    vs  = !((v >= 490) && (v < 492));
    von = act;
    if (win) col = fb_val((h - 64) / 2, v / 2, rnd);
    else if (act) col = 9'h000;
    else col = 9'd0;
  endfunction

  typedef struct {
    bit         src_ok;
    int         h, v;
    bit         fbr;
    logic [8:0] col;
    bit         hs, vs, von, vbl, fs;
    int         ph, pv;
    logic [7:0] px, py;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;
  bit   mon_en = 1'b0;

  // Stimulus-side model of where the raster is
  int cur_h = 0, cur_v = 0, prev_h = 0, prev_v = 0;
  bit prev_rst = 1'b1;

  // Full-frame measurement
  int meas_left = 0, fs_cnt = 0, hs_pulses = 0, hs_width = 0, width_bad = 0, vs_low = 0;
  bit hs_prev = 1'b1;

  task automatic step(input bit r);
    exp_t e;
    int   nh, nv;
    @(negedge pix_clk);
    reset  = r;
    mon_en = 1'b1;
    e.vbl  = !r && (cur_v >= 480);
    e.fs   = !r && (cur_h == 0) && (cur_v == 0);
    e.fbr  = fb_rand;
    if (r || prev_rst) begin
      e.src_ok = 1'b0; e.h = -1; e.v = -1;
      e.col = 9'd0; e.hs = 1'b1; e.vs = 1'b1; e.von = 1'b0;
    end else begin
      e.src_ok = 1'b1; e.h = prev_h; e.v = prev_v;
      pixel(prev_h, prev_v, fb_rand, e.col, e.hs, e.vs, e.von);
    end
    if (r) begin
      nh = 0; nv = 0;
    end else begin
      nh = (cur_h + 1) % 800;
      nv = (cur_h == 799) ? (cur_v + 1) % 525 : cur_v;
    end
    e.ph = nh; e.pv = nv;
    e.px = ((nh >= 64) && (nh < 576) && (nv < 480)) ? 8'((nh - 64) / 2) : 8'd0;
    e.py = (nv < 480) ? 8'(nv / 2) : 8'd0;
    q.push_back(e);
    prev_h = cur_h; prev_v = cur_v; prev_rst = r;
    cur_h = nh; cur_v = nv;
  endtask

  task automatic chk(input string name, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", name, got, want);
    end
  endtask

  // Monitor: one popped expectation per clock edge
  initial begin
    exp_t e;
    forever begin
      @(posedge pix_clk);
      #1;
      if (mon_en) begin
        if (q.size() == 0) begin
          total++; bad++;
          $display("FAIL sb_empty got=0 want=1 entries");
        end else begin
          e = q.pop_front();
          total++;
          if ({vga_r, vga_g, vga_b} !== e.col || vga_hs !== e.hs || vga_vs !== e.vs ||
              video_on !== e.von || vblank !== e.vbl || frame_start !== e.fs ||
              pix_ptr_x !== e.px || pix_ptr_y !== e.py) begin
            bad++;
            $display("FAIL out src=(%0d,%0d) got rgb=%h hs=%b vs=%b von=%b vbl=%b fs=%b px=%0d py=%0d want rgb=%h hs=%b vs=%b von=%b vbl=%b fs=%b px=%0d py=%0d",
                     e.h, e.v, {vga_r, vga_g, vga_b}, vga_hs, vga_vs, video_on, vblank,
                     frame_start, pix_ptr_x, pix_ptr_y, e.col, e.hs, e.vs, e.von, e.vbl,
                     e.fs, e.px, e.py);
          end
          if (e.src_ok && !e.fbr && e.h == 66 && e.v == 3)
            chk("fb_66_3", int'({vga_r, vga_g, vga_b}), int'({3'd1, 3'd1, 3'd5}));
          if (e.src_ok && e.h == 10 && e.v == 100)
            chk("border_10_100", int'({video_on, vga_r, vga_g, vga_b}), int'({1'b1, 9'h000}));
          if (e.src_ok && e.h == 700 && e.v == 100)
            chk("blank_700_100", int'({video_on, vga_r, vga_g, vga_b}), 0);
          if (e.pv < 480 && (e.ph == 64 || e.ph == 65)) chk("ptr_x_lo", int'(pix_ptr_x), 0);
          if (e.pv < 480 && e.ph == 575) chk("ptr_x_hi", int'(pix_ptr_x), 255);
          if (e.pv == 479 && e.ph == 100) chk("ptr_y_hi", int'(pix_ptr_y), 239);
        end
        if (video_on !== 1'b1) chk("blank_rgb", int'({vga_r, vga_g, vga_b}), 0);
        if (meas_left > 0) begin
          meas_left--;
          fs_cnt += int'(frame_start);
          vs_low += int'(!vga_vs);
          if (hs_prev && !vga_hs) hs_pulses++;
          if (!vga_hs) hs_width++;
          if (!hs_prev && vga_hs) begin
            if (hs_width != 96) width_bad++;
            hs_width = 0;
          end
          hs_prev = vga_hs;
        end
      end
    end
  end

  initial begin
    int n;
    for (int i = 0; i < 256*240; i++) fb_mem[i] = 9'($urandom);
    rgb = 9'd0;
    repeat (4) step(1'b1);
    // Random mid-frame resets
    for (int k = 0; k < 4; k++) begin
      n = $urandom_range(2000, 50);
      repeat (n) step(1'b0);
      n = $urandom_range(4, 1);
      repeat (n) step(1'b1);
    end
    // Clean release, then one full frame plus the wrap into the next
    repeat (2) step(1'b1);
    meas_left = 800 * 525;
    repeat (800 * 525 + 5) step(1'b0);
    chk("frame_starts", fs_cnt, 1);
    chk("hs_pulses", hs_pulses, 525);
    chk("hs_width_errs", width_bad, 0);
    chk("vs_low_cycles", vs_low, 1600);
    // Random image for the rest; in-flight reads are in the left border here
    fb_rand = 1'b1;
    n = 0;
    while (!(cur_h == 300 && cur_v == 200) && n < 900000) begin
      step(1'b0);
      n++;
    end
    if (n >= 900000) begin
      total++; bad++;
      $display("FAIL reach_300_200 got=timeout want=reached");
    end
    repeat (3) step(1'b1);
    repeat (2000) step(1'b0);
    @(posedge pix_clk);
    #5;
    mon_en = 1'b0;
    chk("sb_drained", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vga_scanout.md
VGA_SCANOUT -- requirements
Module: vga_scanout

Interface
REQ-001 The block SHALL be parameterised as follows, one parameter per line:
- H_ACTIVE, 640, visible pixels per line.
- H_FP, 16, horizontal front porch in pixels.
- H_SYNC, 96, hsync width in pixels.
- H_BP, 48, horizontal back porch in pixels.
- V_ACTIVE, 480, visible lines.
- V_FP, 10, vertical front porch in lines.
- V_SYNC, 2, vsync width in lines.
- V_BP, 33, vertical back porch in lines.
- X_OFFSET, 64, left border width before the NES image.
- BORDER_RGB, 9'h000, RRRGGGBBB border colour.

REQ-002 The block SHALL have the following ports, listed as name, direction, width, meaning:
- pix_clk, in, 1, the single clock (25.175 MHz pixel clock).
- reset, in, 1, synchronous, active-high.
- pix_ptr_x, out, 8, frame-buffer read column, 0..255.
- pix_ptr_y, out, 8, frame-buffer read row, 0..239.
- rgb, in, 9, frame-buffer pixel RRRGGGBBB, valid 1 cycle after the pointers.
- vga_r, vga_g, vga_b, out, 3 each, registered colour.
- vga_hs, vga_vs, out, 1 each, registered syncs, active-low.
- video_on, out, 1, registered; high while vga_r/g/b carry active-area pixels.
- vblank, out, 1, high while vcount >= V_ACTIVE (PPU NMI source).
- frame_start, out, 1, single-cycle pulse at start of each frame.

REQ-003 Clock and reset SHALL be exactly one clock (pix_clk) and a synchronous, active-high reset (reset); there SHALL be no other clock domain.

Function
REQ-004 hcount SHALL count 0..H_TOTAL-1 (800) and wrap to 0; vcount SHALL increment only when hcount wraps, count 0..V_TOTAL-1 (525) and wrap to 0.
REQ-005 At hcount=799 and vcount=524 simultaneously, both counters SHALL become 0 on the next edge.
REQ-006 The NES window SHALL be X_OFFSET <= hcount < X_OFFSET+512 and vcount < 480; each NES pixel SHALL be doubled in both axes.
REQ-007 pix_ptr_x SHALL be (hcount-X_OFFSET)>>1 inside the window and 0 outside; pix_ptr_y SHALL be vcount>>1 for vcount<480 and 0 otherwise; both SHALL be combinational from the counters.
REQ-008 Stage 1 SHALL register in_window, active (hcount<640 && vcount<480), hs_n and vs_n from the current counters, aligned with the frame-buffer's 1-cycle read latency.
REQ-009 Stage 2 SHALL register the outputs: vga_r/g/b = rgb if stage1 in_window, BORDER_RGB if stage1 active and not in_window, else 0; vga_hs, vga_vs and video_on SHALL be taken from stage 1.
REQ-010 The total latency from counter state (h,v) to the vga_* outputs for that position SHALL be exactly 2 cycles.
REQ-011 hs_n SHALL be 0 for H_ACTIVE+H_FP <= hcount < H_ACTIVE+H_FP+H_SYNC (656..751) and 1 otherwise.
REQ-012 vs_n SHALL be 0 for V_ACTIVE+V_FP <= vcount < V_ACTIVE+V_FP+V_SYNC (490..491) and 1 otherwise.
REQ-013 vblank SHALL be registered, going high the cycle after vcount becomes 480 and low the cycle after vcount wraps to 0.
REQ-014 frame_start SHALL be registered and high for exactly one cycle, the cycle after the counters equal (0,0).
REQ-015 RGB SHALL be driven 0 during all blanking cycles; nonzero output with video_on=0 SHALL be an error.

Reset
REQ-016 While reset is asserted, hcount, vcount and all pipeline registers SHALL be 0, except the sync registers, which SHALL be 1.
REQ-017 The outputs under reset SHALL be vga_r/g/b=0, vga_hs=1, vga_vs=1, video_on=0, vblank=0 and frame_start=0.
REQ-018 Reset asserted mid-frame SHALL take effect on the next edge; the first cycle after release SHALL have counters (0,0), and frame_start SHALL pulse one cycle later.

Verification
REQ-019 Release reset, then run 800*525 cycles: the bench SHALL see exactly one frame_start, 525 hsync pulses each 96 cycles wide, and one vsync pulse of 1600 cycles.
REQ-020 Model the frame buffer as rgb = {pix_ptr_x[2:0], pix_ptr_y[2:0], 3'b101} with 1-cycle latency: at hcount=66, vcount=3, two cycles later vga_r/g/b SHALL be 1/1/5 (ptr 1,1).
REQ-021 Border check: at hcount=10, vcount=100 the output two cycles later SHALL equal BORDER_RGB with video_on=1; at hcount=700 the output SHALL be 0 with video_on=0.
REQ-022 Wrap check: at counters (799,524) the next cycle SHALL show (0,0), frame_start SHALL pulse on the following cycle, and vblank SHALL fall.
REQ-023 Assert reset at hcount=300, vcount=200 for 3 cycles: the outputs SHALL hold their reset values during reset, and counting SHALL restart from (0,0) after release.
REQ-024 Doubling check: hcount 64 and 65 SHALL both produce pix_ptr_x=0, hcount 575 SHALL produce 255, and vcount 479 SHALL produce pix_ptr_y=239.
